// File: rtl/kronos_types.sv
// Shared pipeline types for the Kronos front end.
// pipeIFID_t carries one fetched instruction word and its address from IF to ID.
package kronos_types;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } pipeIFID_t;

endpackage

// File: rtl/kronos_pfbuf.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO with flush and a flop-sourced head.
// A pushed entry becomes visible on head_o one cycle later; there is no bypass.
module kronos_pfbuf
   import kronos_types::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
)(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          push_i,
   input  pipeIFID_t     push_data_i,
   input  logic          pop_i,
   output pipeIFID_t     head_o,
   output logic          head_vld_o,
   output logic [CW-1:0] count_o
);

   pipeIFID_t     mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   // DEPTH is a power of two, so plain pointer increments wrap modulo DEPTH.
   always_comb begin
      wptr_d  = push_i ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop_i  ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q + CW'(push_i) - CW'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) mem_q[wptr_q] <= push_data_i;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign head_o     = mem_q[rptr_q];
   assign head_vld_o = (count_q != '0);
   assign count_o    = count_q;

endmodule

// File: rtl/kronos_if_prefetch.sv
// Instruction prefetch stage: one outstanding memory request at a time, results queued
// in kronos_pfbuf and presented to ID as {pc, ir} with valid/ready handshaking.
module kronos_if_prefetch
   import kronos_types::*;
#(
   parameter logic [31:0] BOOT_ADDR = 32'h0,
   parameter int          DEPTH     = 2
)(
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] instr_addr,
   output logic        instr_req,
   input  logic [31:0] instr_data,
   input  logic        instr_ack,
   output pipeIFID_t   fetch,
   output logic        fetch_vld,
   input  logic        fetch_rdy,
   input  logic        branch,
   input  logic [31:0] branch_target
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // pc_q is the address currently in flight when inflight_q=1, else the next one to request.
   logic          inflight_q, inflight_d;
   logic [31:0]   pc_q, pc_d;
   logic          ack_ok;
   logic          pop;
   logic [CW-1:0] buf_count;
   logic [CW-1:0] count_next;
   pipeIFID_t     head;
   pipeIFID_t     push_data;
   logic          head_vld;
   logic          unused_tgt_lsb;

   kronos_pfbuf #(.DEPTH(DEPTH)) u_pfbuf (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (branch),
      .push_i      (ack_ok),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .head_vld_o  (head_vld),
      .count_o     (buf_count)
   );

   always_comb begin
      fetch_vld    = head_vld & ~rst;
      fetch        = rst ? '0 : head;
      // Acks landing in a branch cycle belong to the old stream; in the cycle after a
      // branch nothing is in flight, so those acks fall away through inflight_q.
      ack_ok       = instr_ack & inflight_q & ~branch & ~rst;
      pop          = fetch_vld & fetch_rdy;
      push_data.pc = pc_q;
      push_data.ir = instr_data;
      count_next   = buf_count + CW'(ack_ok) - CW'(pop);
      instr_addr   = ack_ok ? pc_q + 32'd4 : pc_q;
      // Reserve a slot for the response: count_next + 1 <= DEPTH.
      instr_req    = ~rst & ~branch & (count_next < DEPTH_C);
      inflight_d   = instr_req;
      pc_d         = branch ? {branch_target[31:2], 2'b00} : instr_addr;
   end

   assign unused_tgt_lsb = ^branch_target[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         pc_q       <= {BOOT_ADDR[31:2], 2'b00};
      end else begin
         inflight_q <= inflight_d;
         pc_q       <= pc_d;
      end
   end

endmodule
